// File: rtl/nios2_oci_dct_pkg.sv
// Shared types and default sizing for the OCI DCT trace-capture monitor.
package nios2_oci_dct_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } dct_state_e;

    localparam int DEF_DATA_W = 30;
    localparam int DEF_CNT_W  = 4;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_TOT_W  = 16;

endpackage

// File: rtl/nios2_oci_dct_fifo.sv
// First-word-fall-through capture FIFO; head entry reads as zero while empty.
module nios2_oci_dct_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign rd_data = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push)
                wptr <= wptr + AW'(1);
            if (do_pop)
                rptr <= rptr + AW'(1);
            case ({push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage is not reset; empty gating keeps stale contents off rd_data.
    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= wr_data;
    end

endmodule

// File: rtl/nios2_oci_dct_monitor.sv
// Captures qualified DCT trace words into a FIFO, accumulates their counts,
// and sequences capture -> drain -> done around the test end handshake.
module nios2_oci_dct_monitor
    import nios2_oci_dct_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int TOT_W  = DEF_TOT_W,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dct_valid,
    input  logic [DATA_W-1:0] dct_buffer,
    input  logic [CNT_W-1:0]  dct_count,
    input  logic              test_ending,
    input  logic              test_has_ended,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  rd_count,
    output logic [LW-1:0]     fill_level,
    output logic [TOT_W-1:0]  total_count,
    output logic              overflow,
    output logic [1:0]        state,
    output logic              done
);

    localparam int ENT_W = CNT_W + DATA_W;
    localparam int SUM_W = ((TOT_W > CNT_W) ? TOT_W : CNT_W) + 1;

    dct_state_e        cur_st, nxt_st;
    logic              capturing, push, pop, full, empty, drained;
    logic [ENT_W-1:0]  head;
    logic [SUM_W-1:0]  tot_sum;

    assign rd_valid = !empty;
    assign pop      = rd_valid && rd_ready;
    // A full FIFO still accepts when the same edge frees a slot.
    assign push     = capturing && dct_valid && (!full || pop);
    assign drained  = empty || (fill_level == LW'(1) && pop);

    nios2_oci_dct_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data ({dct_count, dct_buffer}),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (fill_level)
    );

    assign {rd_count, rd_data} = head;

    always_ff @(posedge clk) begin
        if (reset)
            cur_st <= ST_IDLE;
        else
            cur_st <= nxt_st;
    end

    always_comb begin
        nxt_st = cur_st;
        case (cur_st)
            ST_IDLE: begin
                if (test_ending)
                    nxt_st = ST_DRAIN;
                else if (dct_valid)
                    nxt_st = ST_CAPTURE;
            end
            ST_CAPTURE: if (test_ending) nxt_st = ST_DRAIN;
            ST_DRAIN:   if (drained && test_has_ended) nxt_st = ST_DONE;
            default:    nxt_st = ST_DONE;
        endcase
    end

    always_comb begin
        capturing = (cur_st == ST_IDLE) || (cur_st == ST_CAPTURE);
        done      = (cur_st == ST_DONE);
        state     = cur_st;
    end

    assign tot_sum = SUM_W'(total_count) + SUM_W'(dct_count);

    always_ff @(posedge clk) begin
        if (reset) begin
            total_count <= '0;
            overflow    <= 1'b0;
        end else begin
            if (push)
                total_count <= (tot_sum[SUM_W-1:TOT_W] != '0) ? '1 : tot_sum[TOT_W-1:0];
            if (capturing && dct_valid && !push)
                overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_nios2_oci_dct_monitor.sv
// Directed bench for the DCT monitor: a default instance and a 4-bit-total
// instance share stimulus and are compared every cycle against a queue model.
module tb_nios2_oci_dct_monitor;

    localparam int DATA_W = 30;
    localparam int CNT_W  = 4;
    localparam int DEPTH  = 16;
    localparam int LW     = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              dct_valid, test_ending, test_has_ended, rd_ready;
    logic [DATA_W-1:0] dct_buffer;
    logic [CNT_W-1:0]  dct_count;

    logic              rd_valid, overflow, done;
    logic [DATA_W-1:0] rd_data;
    logic [CNT_W-1:0]  rd_count;
    logic [LW-1:0]     fill_level;
    logic [15:0]       total_count;
    logic [1:0]        state;

    logic              s_rd_valid, s_overflow, s_done;
    logic [DATA_W-1:0] s_rd_data;
    logic [CNT_W-1:0]  s_rd_count;
    logic [LW-1:0]     s_fill_level;
    logic [3:0]        s_total_count;
    logic [1:0]        s_state;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    nios2_oci_dct_monitor dut (
        .clk(clk), .reset(reset), .dct_valid(dct_valid), .dct_buffer(dct_buffer),
        .dct_count(dct_count), .test_ending(test_ending), .test_has_ended(test_has_ended),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .rd_count(rd_count),
        .fill_level(fill_level), .total_count(total_count), .overflow(overflow),
        .state(state), .done(done)
    );

    nios2_oci_dct_monitor #(.TOT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .dct_valid(dct_valid), .dct_buffer(dct_buffer),
        .dct_count(dct_count), .test_ending(test_ending), .test_has_ended(test_has_ended),
        .rd_ready(rd_ready), .rd_valid(s_rd_valid), .rd_data(s_rd_data), .rd_count(s_rd_count),
        .fill_level(s_fill_level), .total_count(s_total_count), .overflow(s_overflow),
        .state(s_state), .done(s_done)
    );

    // Behavioural model: a queue of {count,data}, a phase number and two totals.
    logic [CNT_W+DATA_W-1:0] q[$];
    int m_phase, m_tot, m_tot4;
    bit m_ovf;

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            m_phase = 0; m_tot = 0; m_tot4 = 0; m_ovf = 1'b0;
        end else begin
            bit open, popped, wrote;
            open   = (m_phase < 2);
            popped = (q.size() > 0) && rd_ready;
            wrote  = open && dct_valid && ((q.size() < DEPTH) || popped);
            if (open && dct_valid && !wrote) m_ovf = 1'b1;
            if (popped) void'(q.pop_front());
            if (wrote) begin
                q.push_back({dct_count, dct_buffer});
                m_tot  = (m_tot + int'(dct_count) > 65535) ? 65535 : m_tot + int'(dct_count);
                m_tot4 = (m_tot4 + int'(dct_count) > 15) ? 15 : m_tot4 + int'(dct_count);
            end
            if (open && test_ending)                           m_phase = 2;
            else if (m_phase == 0 && dct_valid)                m_phase = 1;
            else if (m_phase == 2 && q.size() == 0 && test_has_ended) m_phase = 3;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic [CNT_W+DATA_W-1:0] h;
            h = (q.size() > 0) ? q[0] : '0;
            chk("rd_valid",      64'(rd_valid),     64'(q.size() > 0));
            chk("rd_data",       64'(rd_data),      64'(h[DATA_W-1:0]));
            chk("rd_count",      64'(rd_count),     64'(h[CNT_W+DATA_W-1:DATA_W]));
            chk("fill_level",    64'(fill_level),   64'(q.size()));
            chk("total_count",   64'(total_count),  64'(m_tot));
            chk("overflow",      64'(overflow),     64'(m_ovf));
            chk("state",         64'(state),        64'(m_phase));
            chk("done",          64'(done),         64'(m_phase == 3));
            chk("sat.rd_data",   64'(s_rd_data),    64'(h[DATA_W-1:0]));
            chk("sat.fill",      64'(s_fill_level), 64'(q.size()));
            chk("sat.total",     64'(s_total_count),64'(m_tot4));
            chk("sat.overflow",  64'(s_overflow),   64'(m_ovf));
            chk("sat.state",     64'(s_state),      64'(m_phase));
            chk("sat.rd_valid",  64'(s_rd_valid),   64'(q.size() > 0));
            chk("sat.rd_count",  64'(s_rd_count),   64'(h[CNT_W+DATA_W-1:DATA_W]));
            chk("sat.done",      64'(s_done),       64'(m_phase == 3));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dct_valid = 0; dct_buffer = '0; dct_count = '0;
        test_ending = 0; test_has_ended = 0; rd_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1; tick(); reset = 0;
    endtask

    task automatic wr(input logic [DATA_W-1:0] d, input logic [CNT_W-1:0] c);
        dct_valid = 1; dct_buffer = d; dct_count = c; tick();
        dct_valid = 0;
    endtask

    initial begin
        idle_inputs();
        reset = 1; tick(); tick();
        reset = 0; chk_en = 1'b1;
        chk("reset.state", 64'(state), 64'd0);
        chk("reset.fill", 64'(fill_level), 64'd0);
        chk("reset.rd_data", 64'(rd_data), 64'd0);

        // three writes, test_has_ended alone must not move the FSM
        test_has_ended = 1;
        for (int i = 0; i < 3; i++) wr(30'h0ABC0000 + 30'(i), 4'(i + 1));
        test_has_ended = 0; tick();
        chk("w3.fill", 64'(fill_level), 64'd3);
        chk("w3.total", 64'(total_count), 64'd6);
        chk("w3.state", 64'(state), 64'd1);
        chk("w3.head", 64'(rd_data), 64'h0ABC0000);

        // overflow: 17 writes into 16 entries, 17th must vanish
        do_reset();
        for (int i = 0; i < 17; i++) wr(30'(i), 4'd1);
        chk("ovf.fill", 64'(fill_level), 64'd16);
        chk("ovf.flag", 64'(overflow), 64'd1);
        chk("ovf.total", 64'(total_count), 64'd16);
        chk("ovf.sat_total", 64'(s_total_count), 64'd15);
        rd_ready = 1;
        for (int k = 0; k < 16; k++) begin
            chk("ovf.readout", 64'(rd_data), 64'(k));
            tick();
        end
        rd_ready = 0;
        chk("ovf.empty", 64'(rd_valid), 64'd0);
        chk("ovf.sticky", 64'(overflow), 64'd1);

        // full FIFO with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 16; i++) wr(30'h100 + 30'(i), 4'd1);
        rd_ready = 1; wr(30'h3FFFFFFF, 4'd2); rd_ready = 0;
        chk("pp.fill", 64'(fill_level), 64'd16);
        chk("pp.ovf", 64'(overflow), 64'd0);
        chk("pp.head", 64'(rd_data), 64'h101);
        chk("pp.total", 64'(total_count), 64'd18);

        // drain to done; write with test_ending is still accepted
        do_reset();
        wr(30'h11, 4'd5);
        test_ending = 1; wr(30'h22, 4'd6); test_ending = 0;
        chk("dr.state", 64'(state), 64'd2);
        chk("dr.fill", 64'(fill_level), 64'd2);
        chk("dr.total", 64'(total_count), 64'd11);
        test_has_ended = 1; rd_ready = 1; dct_valid = 1; dct_count = 4'd7; dct_buffer = 30'h33;
        tick();
        chk("dr.pop1.fill", 64'(fill_level), 64'd1);
        chk("dr.pop1.head", 64'(rd_data), 64'h22);
        chk("dr.pop1.state", 64'(state), 64'd2);
        tick();
        chk("dr.done.state", 64'(state), 64'd3);
        chk("dr.done.flag", 64'(done), 64'd1);
        tick(); tick();
        chk("dr.ignored.fill", 64'(fill_level), 64'd0);
        chk("dr.ignored.total", 64'(total_count), 64'd11);
        chk("dr.ignored.ovf", 64'(overflow), 64'd0);
        idle_inputs();

        // saturation on the 4-bit total, then reset mid-drain with all inputs active
        do_reset();
        wr(30'h7, 4'd15);
        test_ending = 1; wr(30'h8, 4'd15); test_ending = 0;
        chk("sat.total16", 64'(total_count), 64'd30);
        chk("sat.total4", 64'(s_total_count), 64'd15);
        chk("sat.state", 64'(state), 64'd2);
        reset = 1; dct_valid = 1; test_ending = 1; rd_ready = 1; test_has_ended = 1;
        tick();
        chk("rst.state", 64'(state), 64'd0);
        chk("rst.fill", 64'(fill_level), 64'd0);
        chk("rst.rd_valid", 64'(rd_valid), 64'd0);
        chk("rst.rd_data", 64'(rd_data), 64'd0);
        chk("rst.rd_count", 64'(rd_count), 64'd0);
        chk("rst.total", 64'(total_count), 64'd0);
        chk("rst.sat_total", 64'(s_total_count), 64'd0);
        chk("rst.ovf", 64'(overflow), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        reset = 0; idle_inputs(); tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nios2_oci_dct_monitor.md
NIOS2_OCI_DCT_MONITOR -- requirements
Module: nios2_oci_dct_monitor

Interface
REQ-001 Parameter DATA_W, default 30, width of dct_buffer trace word.
REQ-002 Parameter CNT_W, default 4, width of dct_count field.
REQ-003 Parameter DEPTH, default 16, capture FIFO entries; power of 2, >= 2.
REQ-004 Parameter TOT_W, default 16, width of total_count accumulator.
REQ-005 Ports (clock and reset first):
- clk  in  1  single clock; all logic rising-edge.
- reset  in  1  synchronous, active-high.
- dct_valid  in  1  dct_buffer/dct_count qualify this cycle.
- dct_buffer  in  DATA_W  trace word.
- dct_count  in  CNT_W  frame count carried with the word.
- test_ending  in  1  stop capturing, begin drain.
- test_has_ended  in  1  test complete; permits DONE once empty.
- rd_ready  in  1  consumer accepts head entry.
- rd_valid  out  1  FIFO non-empty.
- rd_data  out  DATA_W  head entry trace word.
- rd_count  out  CNT_W  head entry count field.
- fill_level  out  clog2(DEPTH)+1  entries held.
- total_count  out  TOT_W  sum of accepted dct_count.
- overflow  out  1  sticky, a word was dropped.
- state  out  2  current FSM state.
- done  out  1  state == DONE.

Function
REQ-006 FSM states, encoding: IDLE=0, CAPTURE=1, DRAIN=2, DONE=3.
REQ-007 IDLE: dct_valid=1 writes the entry and moves to CAPTURE next cycle.
REQ-008 Write accepted in IDLE/CAPTURE when dct_valid=1 and (not full, or a pop occurs the same cycle).
REQ-009 dct_valid=1 while full with no pop: word dropped, overflow set next cycle, stays set until reset.
REQ-010 Accepted write: total_count += zero-extended dct_count, saturating at all-ones.
REQ-011 test_ending=1 in IDLE or CAPTURE: move to DRAIN; a write in that same cycle is still accepted.
REQ-012 DRAIN and DONE: dct_valid ignored; no write, no overflow, total_count frozen.
REQ-013 DRAIN -> DONE when FIFO empty (after this cycle's pop) and test_has_ended=1 in the same cycle; otherwise stay.
REQ-014 test_has_ended without prior test_ending: no effect in IDLE/CAPTURE.
REQ-015 DONE held until reset; done=1 only in DONE.
REQ-016 Read port first-word-fall-through in every state: rd_valid=!empty; rd_data/rd_count show head entry.
REQ-017 Pop when rd_valid and rd_ready; rd_ready while empty has no effect.
REQ-018 Write-to-rd_valid latency: entry written at edge N is visible after edge N (1 cycle).
REQ-019 Pointers wrap modulo DEPTH; fill_level updates same edge as push/pop; push+pop leaves it unchanged.
REQ-020 Storage holds {dct_count, dct_buffer} per entry; order strictly FIFO.

Reset
REQ-021 reset=1 at an edge: state=IDLE, pointers and fill_level=0, rd_valid=0, total_count=0, overflow=0, done=0.
REQ-022 rd_data/rd_count reset to 0.
REQ-023 reset dominates all inputs including concurrent dct_valid, test_ending, rd_ready; mid-operation contents discarded.

Structure
REQ-024 Package nios2_oci_dct_pkg holds state enum/encoding and default parameter constants.
REQ-025 One sub-module, nios2_oci_dct_fifo (DEPTH x (CNT_W+DATA_W), FWFT, push/pop/full/empty/level); FSM and accumulator in top.

Verification
REQ-026 Reset, 3 writes (counts 1,2,3), rd_ready=0 -> fill_level=3, total_count=6, state=CAPTURE, rd_data=first word.
REQ-027 DEPTH=16, 17 writes, no reads -> fill_level=16, overflow=1, 17th word absent in readout.
REQ-028 Full FIFO, dct_valid and rd_ready same cycle -> write accepted, fill_level stays 16, overflow=0.
REQ-029 test_ending with 2 entries, test_has_ended held 1, rd_ready=1 -> 2 pops, DONE on cycle emptying FIFO, later dct_valid ignored.
REQ-030 TOT_W=4, counts 15 then 15 -> total_count=15 (saturated); reset mid-DRAIN -> all outputs per REQ-021 next cycle.
